// File: rtl/video_timing_gen.sv
// Video timing generator: raster counters, sync/DE decode delayed to match the pixel pipeline,
// registered and blanked RGB output. Optional feature macro: VTG_TEST_PATTERN_EN (adds TEST_PAT colour bars).
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int PIPE_DLY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
`ifdef VTG_TEST_PATTERN_EN
  input  logic        TEST_PAT,
`endif
  output logic [10:0] H_CNT,
  output logic [10:0] V_CNT,
  output logic        LINE_START,
  output logic        FRAME_START,
  output logic [15:0] FRAME_CNT,
  input  logic [7:0]  RED_IN,
  input  logic [7:0]  GREEN_IN,
  input  logic [7:0]  BLUE_IN,
  output logic [7:0]  RED,
  output logic [7:0]  GREEN,
  output logic [7:0]  BLUE,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        DE
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_W  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
      $error("video_timing_gen: H_TOTAL/V_TOTAL must not exceed 2048");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 15) begin : g_bad_dly
      $error("video_timing_gen: PIPE_DLY must be in 0..15");
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      H_CNT     <= '0;
      V_CNT     <= '0;
      FRAME_CNT <= '0;
    end else if (EN) begin
      if (H_CNT == H_LAST) begin
        H_CNT <= '0;
        if (V_CNT == V_LAST) begin
          V_CNT     <= '0;
          FRAME_CNT <= FRAME_CNT + 16'd1;
        end else begin
          V_CNT <= V_CNT + 11'd1;
        end
      end else begin
        H_CNT <= H_CNT + 11'd1;
      end
    end
  end

  // Pulses follow the live counters, so they are visible in the very first cycle after reset.
  assign LINE_START  = EN && !RST && (H_CNT == 11'd0);
  assign FRAME_START = LINE_START && (V_CNT == 11'd0);

  logic de_raw, hs_raw, vs_raw;
  assign de_raw = EN && (H_CNT < H_ACT_W) && (V_CNT < V_ACT_W);
  assign hs_raw = (H_CNT >= HS_START) && (H_CNT <= HS_END);
  assign vs_raw = (V_CNT >= VS_START) && (V_CNT <= VS_END);

`ifdef VTG_TEST_PATTERN_EN
  localparam int DW = 14;
  logic [DW-1:0] raw_vec;
  assign raw_vec = {H_CNT, de_raw, hs_raw, vs_raw};
`else
  localparam int DW = 3;
  logic [DW-1:0] raw_vec;
  assign raw_vec = {de_raw, hs_raw, vs_raw};
`endif

  logic [DW-1:0] tap_vec;

  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign tap_vec = raw_vec;
    end else begin : g_dly
      logic [DW-1:0] dly [PIPE_DLY];
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          for (int i = 0; i < PIPE_DLY; i++) dly[i] <= '0;
        end else begin
          dly[0] <= raw_vec;
          for (int i = 1; i < PIPE_DLY; i++) dly[i] <= dly[i-1];
        end
      end
      assign tap_vec = dly[PIPE_DLY-1];
    end
  endgenerate

  logic tap_de, tap_hs, tap_vs;
  assign tap_de = tap_vec[2];
  assign tap_hs = tap_vec[1];
  assign tap_vs = tap_vec[0];

  logic [7:0] pix_r, pix_g, pix_b;

`ifdef VTG_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam logic [10:0] BAR_W_11 = 11'(BAR_W);
  logic [10:0] tap_h;
  logic [2:0]  bar_sel;
  assign tap_h   = tap_vec[13:3];
  assign bar_sel = 3'(tap_h / BAR_W_11);
  // Bar index bits inverted give {R,G,B}: bar 0 white through bar 7 black.
  assign pix_r = TEST_PAT ? (bar_sel[2] ? 8'h00 : 8'hFF) : RED_IN;
  assign pix_g = TEST_PAT ? (bar_sel[1] ? 8'h00 : 8'hFF) : GREEN_IN;
  assign pix_b = TEST_PAT ? (bar_sel[0] ? 8'h00 : 8'hFF) : BLUE_IN;
`else
  assign pix_r = RED_IN;
  assign pix_g = GREEN_IN;
  assign pix_b = BLUE_IN;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RED   <= '0;
      GREEN <= '0;
      BLUE  <= '0;
      DE    <= 1'b0;
      HSYNC <= ~HS_POL;
      VSYNC <= ~VS_POL;
    end else begin
      DE    <= tap_de;
      HSYNC <= tap_hs ? HS_POL : ~HS_POL;
      VSYNC <= tap_vs ? VS_POL : ~VS_POL;
      RED   <= tap_de ? pix_r : 8'h00;
      GREEN <= tap_de ? pix_g : 8'h00;
      BLUE  <= tap_de ? pix_b : 8'h00;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen on a small raster; a linear-position model predicts every output.
module tb_video_timing_gen;

  localparam int HA = 16, HF = 3, HS = 4, HB = 5;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 2;
  localparam bit HP = 1'b0;
  localparam bit VP = 1'b1;
  localparam int PD = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic [7:0]  RED_IN, GREEN_IN, BLUE_IN;
  logic [10:0] H_CNT, V_CNT;
  logic        LINE_START, FRAME_START;
  logic [15:0] FRAME_CNT;
  logic [7:0]  RED, GREEN, BLUE;
  logic        HSYNC, VSYNC, DE;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .PIPE_DLY(PD)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .H_CNT(H_CNT), .V_CNT(V_CNT),
    .LINE_START(LINE_START), .FRAME_START(FRAME_START), .FRAME_CNT(FRAME_CNT),
    .RED_IN(RED_IN), .GREEN_IN(GREEN_IN), .BLUE_IN(BLUE_IN),
    .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

  sync_t       dq[$];
  int          model_pos;
  int          model_frames;
  logic [23:0] last_rgb;
  int          checks = 0;
  int          failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic sync_t decode(input int pos, input logic en);
    sync_t s;
    int h, v;
    h = pos % HT;
    v = pos / HT;
    s.de = en && (h < HA) && (v < VA);
    s.hs = (h >= HA + HF) && (h < HA + HF + HS);
    s.vs = (v >= VA + VF) && (v < VA + VF + VS);
    return s;
  endfunction

  task automatic modelReset();
    model_pos    = 0;
    model_frames = 0;
    last_rgb     = 24'h0;
    dq.delete();
    repeat (PD + 1) dq.push_back(sync_t'(3'b000));
  endtask

  // One pixel clock: drive inputs, compare outputs of this cycle, advance the model, step the clock.
  task automatic applyStimulus(input logic en, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    sync_t exp_s;
    int h, v;
    EN = en; RED_IN = r; GREEN_IN = g; BLUE_IN = b;
    #1;
    h = model_pos % HT;
    v = model_pos / HT;
    exp_s = dq[0];
    checkOutput("h_cnt", 32'(H_CNT), 32'(h));
    checkOutput("v_cnt", 32'(V_CNT), 32'(v));
    checkOutput("line_start", 32'(LINE_START), 32'(en && h == 0));
    checkOutput("frame_start", 32'(FRAME_START), 32'(en && model_pos == 0));
    checkOutput("frame_cnt", 32'(FRAME_CNT), 32'(model_frames % 65536));
    checkOutput("de", 32'(DE), 32'(exp_s.de));
    checkOutput("hsync", 32'(HSYNC), 32'(exp_s.hs ? HP : !HP));
    checkOutput("vsync", 32'(VSYNC), 32'(exp_s.vs ? VP : !VP));
    checkOutput("rgb", 32'({RED, GREEN, BLUE}), 32'(exp_s.de ? last_rgb : 24'h0));
    dq.push_back(decode(model_pos, en));
    void'(dq.pop_front());
    last_rgb = {r, g, b};
    if (en) begin
      model_pos++;
      if (model_pos == FT) begin
        model_pos = 0;
        model_frames++;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    RST = 1'b1;
    EN  = 1'b1;
    #1;
    checkOutput("rst_h_cnt", 32'(H_CNT), 32'(0));
    checkOutput("rst_v_cnt", 32'(V_CNT), 32'(0));
    checkOutput("rst_frame_cnt", 32'(FRAME_CNT), 32'(0));
    checkOutput("rst_line_start", 32'(LINE_START), 32'(0));
    checkOutput("rst_frame_start", 32'(FRAME_START), 32'(0));
    checkOutput("rst_de", 32'(DE), 32'(0));
    checkOutput("rst_rgb", 32'({RED, GREEN, BLUE}), 32'(0));
    checkOutput("rst_hsync", 32'(HSYNC), 32'(!HP));
    checkOutput("rst_vsync", 32'(VSYNC), 32'(!VP));
    #2;
    RST = 1'b0;
    modelReset();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST = 1'b1; EN = 1'b0; RED_IN = 8'h00; GREEN_IN = 8'h00; BLUE_IN = 8'h00;
    @(posedge CLK);
    #1;
    doReset();

    // Two full frames with RED_IN pinned high, then confirm the completed-frame count.
    for (int i = 0; i < 2 * FT; i++)
      applyStimulus(1'b1, 8'hFF, 8'($urandom), 8'($urandom));
    checkOutput("frame_cnt_after_2", 32'(FRAME_CNT), 32'(2));

    // Freeze mid active line, then resume.
    while (model_pos % HT != 10)
      applyStimulus(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 2 * HT; i++)
      applyStimulus(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));

    // Randomised enable and pixel data.
    for (int i = 0; i < 1500; i++)
      applyStimulus(($urandom_range(0, 9) != 0), 8'($urandom), 8'($urandom), 8'($urandom));

    // Asynchronous reset in the middle of an active line.
    while (model_pos != 3 * HT + 7)
      applyStimulus(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
    doReset();
    for (int i = 0; i < HT + 20; i++)
      applyStimulus(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
